cache_data_array_fill: RTL
==========================

Name: cache_data_array_fill

Overview:
- Parametrised successor to the flop-based cache data array: NUM_BLKS blocks of WORDS_PER_BLK words, each DATA_W bits.
- Uses binary block/word indices instead of one-hot enables.
- Read output is registered, with one-cycle latency; no tri-state outputs.
- Contains a line-fill engine that takes a burst of words from the memory side and writes them sequentially into one block. The cache controller runs misses through this port.

Parameters:
- DATA_W, 16, word width in bits
- WORDS_PER_BLK, 8, words per block; power of two, ≥2
- NUM_BLKS, 64, blocks in the array; power of two, ≥2
- OFF_W, $clog2(WORDS_PER_BLK), word-offset width (derived)
- IDX_W, $clog2(NUM_BLKS), block-index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  CPU read request
- rd_blk  in  IDX_W  read block index
- rd_word  in  OFF_W  read word offset
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid; pulses one cycle after an accepted rd_en
- wr_en  in  1  CPU write request (store hit)
- wr_blk  in  IDX_W  write block index
- wr_word  in  OFF_W  write word offset
- wr_data  in  DATA_W  write data
- wr_stall  out  1  CPU write rejected this cycle; equals fill_busy
- fill_start  in  1  begin fill of fill_blk
- fill_blk  in  IDX_W  block to fill
- fill_valid  in  1  fill_data carries the next word
- fill_data  in  DATA_W  fill word
- fill_busy  out  1  fill engine not IDLE
- fill_done  out  1  one-cycle pulse after the last fill word is written

Behaviour:
- Reset (rst=0, asynchronous):
  - All array words clear to 0.
  - rd_data=0, rd_valid=0, fill_busy=0, fill_done=0.
  - FSM goes to IDLE; word counter=0; latched block index=0.
- FSM states and transitions:
  - IDLE: fill_start=1 → latch fill_blk, counter=0, go to FILL.
  - FILL: each cycle with fill_valid=1 writes fill_data to [latched blk][counter], then counter increments. If the counter equals WORDS_PER_BLK-1 when the write happens, go to DONE. Cycles with fill_valid=0 hold state; gaps are unbounded.
  - DONE: fill_done=1 for exactly one cycle, then go to IDLE. fill_busy stays 1 in DONE.
- fill_start while fill_busy=1 is ignored. fill_start in the same cycle as the DONE→IDLE transition is also ignored, so the earliest new fill is one cycle after fill_done.
- fill_valid in IDLE or DONE is ignored (no write).
- Word order is offset 0..WORDS_PER_BLK-1. The counter wraps to 0 on leaving FILL; it never exceeds WORDS_PER_BLK-1.
- CPU write:
  - With wr_en=1 and fill_busy=0, wr_data is written to [wr_blk][wr_word] at the clock edge.
  - With fill_busy=1, wr_stall=1 and the write is dropped. The controller must hold and retry.
- CPU read:
  - rd_en=1 is always accepted, including during a fill and to the block being filled.
  - rd_data/rd_valid update on the next edge.
  - When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Read/write collision: a read and a write (CPU or fill) to the same word in the same cycle returns the old value (read-before-write).
- Reset mid-fill aborts the fill: no fill_done, FSM returns to IDLE, array cleared.
- Only one write port is active per cycle, because CPU writes are blocked during a fill. There is no write-write conflict.

Decomposition:
- Package cache_pkg holds:
  - the default DATA_W/WORDS_PER_BLK/NUM_BLKS constants;
  - the fill FSM state enum (IDLE, FILL, DONE), 2 bits;
  - typedefs for block index and word offset.
- One sub-module, cache_fill_fsm, owns:
  - state, counter and latched block index;
  - fill_busy, fill_done, and the fill write enable/address.
- The top level holds the storage array, write-port mux and registered read.

Test Plan:
- Reset, then read [5][3] → rd_valid=1 one cycle later, rd_data=0x0000. Then assert rst=0 asynchronously mid-cycle → rd_data=0 immediately.
- Fill block 10 with words 0xA000..0xA007, fill_valid continuous → fill_busy high for 9 cycles, fill_done pulses once. Then read [10][0..7] → 0xA000..0xA007.
- Fill block 3 with fill_valid toggling 1/0 → 8 writes complete and fill_done appears after the 8th valid word. A second fill_start mid-fill is ignored and block 3 is unchanged by it.
- CPU write [7][2]=0x1234 during a fill → wr_stall=1 and the later read returns 0. The same write after fill_done → the read returns 0x1234.
- Same-cycle read and write of [1][1] (old value 0x0001, new 0xBEEF) → rd_data=0x0001. The next read returns 0xBEEF.
- Assert rst=0 after 4 fill words into block 2 → no fill_done, fill_busy=0, [2][0..3] read as 0. A new fill_start is accepted after reset is released.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants and types for the cache data array with line fill
package cache_pkg;

    localparam int DEF_DATA_W        = 16;
    localparam int DEF_WORDS_PER_BLK = 8;
    localparam int DEF_NUM_BLKS      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    typedef logic [$clog2(DEF_NUM_BLKS)-1:0]      blk_idx_t;
    typedef logic [$clog2(DEF_WORDS_PER_BLK)-1:0] word_off_t;

endpackage

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - line-fill sequencer: latches the target block and walks its word offsets
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
    parameter int IDX_W         = $clog2(DEF_NUM_BLKS),
    parameter int OFF_W         = $clog2(DEF_WORDS_PER_BLK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_start,
    input  logic [IDX_W-1:0] fill_blk,
    input  logic             fill_valid,
    output logic             fill_busy,
    output logic             fill_done,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_wblk,
    output logic [OFF_W-1:0] fill_wword
);

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLK - 1);

    fill_state_t      state;
    fill_state_t      state_nxt;
    logic [OFF_W-1:0] cnt;
    logic [IDX_W-1:0] blk_q;

    // State register plus the word counter and latched block index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            blk_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        blk_q <= fill_blk;
                        cnt   <= '0;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        cnt <= (cnt == LAST_WORD) ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state: start only from IDLE, finish on the write of the last offset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = FILL;
            FILL:    if (fill_valid && cnt == LAST_WORD) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: status flags and the fill write port
    always_comb begin
        fill_busy  = (state != IDLE);
        fill_done  = (state == DONE);
        fill_we    = (state == FILL) && fill_valid;
        fill_wblk  = blk_q;
        fill_wword = cnt;
    end

endmodule

// File: rtl/cache_data_array_fill.sv
// rtl/cache_data_array_fill.sv - flop-based cache data array with registered read and line-fill port
module cache_data_array_fill
    import cache_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
    parameter int NUM_BLKS      = DEF_NUM_BLKS,
    localparam int OFF_W        = $clog2(WORDS_PER_BLK),
    localparam int IDX_W        = $clog2(NUM_BLKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_blk,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_blk,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_stall,
    input  logic              fill_start,
    input  logic [IDX_W-1:0]  fill_blk,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done
);

    localparam int DEPTH = NUM_BLKS * WORDS_PER_BLK;
    localparam int AW    = IDX_W + OFF_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [IDX_W-1:0]  fill_wblk;
    logic [OFF_W-1:0]  fill_wword;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    cache_fill_fsm #(
        .WORDS_PER_BLK (WORDS_PER_BLK),
        .IDX_W         (IDX_W),
        .OFF_W         (OFF_W)
    ) u_fill_fsm (
        .clk        (clk),
        .rst        (rst),
        .fill_start (fill_start),
        .fill_blk   (fill_blk),
        .fill_valid (fill_valid),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_we    (fill_we),
        .fill_wblk  (fill_wblk),
        .fill_wword (fill_wword)
    );

    assign wr_stall = fill_busy;

    // Single write port: the fill engine owns it while busy, CPU stores otherwise
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (fill_busy) begin
            we    = fill_we;
            waddr = {fill_wblk, fill_wword};
            wdata = fill_data;
        end else if (wr_en) begin
            we    = 1'b1;
            waddr = {wr_blk, wr_word};
            wdata = wr_data;
        end
    end

    // Storage array, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; nonblocking update gives read-before-write on collisions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[{rd_blk, rd_word}];
            end
        end
    end

endmodule
